coeff_mult_arbiter: RTL and testbench

COEFF_MULT_ARBITER -- requirements
Module: coeff_mult_arbiter

---
 rtl/coeff_mult_arbiter.sv | 153 +++++++++++++++
 tb/tb_coeff_mult_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_mult_arbiter.sv
// coeff_mult_arbiter: two-requester arbiter in front of a shared LAT-cycle modular multiplier.
// Define COEFF_MULT_ARB_RR_EN for round-robin arbitration; default build uses fixed priority (rq0 first).
module coeff_mult_arbiter #(
    parameter int unsigned LAT   = 9,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rq0_valid,
    output logic             rq0_ready,
    input  logic [29:0]      rq0_a,
    input  logic [29:0]      rq0_b,
    input  logic             rq0_mod,
    input  logic [TAG_W-1:0] rq0_tag,
    input  logic             rq1_valid,
    output logic             rq1_ready,
    input  logic [29:0]      rq1_a,
    input  logic [29:0]      rq1_b,
    input  logic             rq1_mod,
    input  logic [TAG_W-1:0] rq1_tag,
    output logic [29:0]      mul_a,
    output logic [29:0]      mul_b,
    output logic             mul_modulus_sel,
    input  logic [29:0]      mul_c,
    output logic             res0_valid,
    output logic [29:0]      res0_data,
    output logic [TAG_W-1:0] res0_tag,
    output logic             res1_valid,
    output logic [29:0]      res1_data,
    output logic [TAG_W-1:0] res1_tag,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

    state_t           state;
    logic             cur_mod;
    logic             pend_mod;
    logic [CNT_W-1:0] cnt;
    logic [LAT-1:0]   trk_v;
    logic [LAT-1:0]   trk_id;
    logic [TAG_W-1:0] trk_tag [LAT];

    logic             win_id;
    logic             win_valid;
    logic             win_mod;
    logic [29:0]      win_a;
    logic [29:0]      win_b;
    logic [TAG_W-1:0] win_tag;
    logic             grant;
    logic             retire;

`ifdef COEFF_MULT_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        win_id = 1'b0;
        if (rq0_valid && rq1_valid)
            win_id = rr_ptr;
        else if (rq1_valid)
            win_id = 1'b1;
    end

    // Pointer names the requester that wins the next tie; it only moves on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 1'b0;
        else if (grant)
            rr_ptr <= ~win_id;
    end
`else
    always_comb begin
        win_id = ~rq0_valid;
    end
`endif

    always_comb begin
        win_valid = win_id ? rq1_valid : rq0_valid;
        win_mod   = win_id ? rq1_mod   : rq0_mod;
        win_a     = win_id ? rq1_a     : rq0_a;
        win_b     = win_id ? rq1_b     : rq0_b;
        win_tag   = win_id ? rq1_tag   : rq0_tag;
        grant     = rst_n && (state == RUN) && win_valid && (win_mod == cur_mod);
        rq0_ready = grant && !win_id;
        rq1_ready = grant && win_id;
        retire    = trk_v[LAT-1];
    end

    assign mul_modulus_sel = cur_mod;
    assign res0_data       = res0_valid ? mul_c : '0;
    assign res1_data       = res1_valid ? mul_c : '0;
    assign busy            = (state != RUN) || (cnt != '0) || res0_valid || res1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            cur_mod    <= 1'b0;
            pend_mod   <= 1'b0;
            cnt        <= '0;
            trk_v      <= '0;
            trk_id     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res0_tag   <= '0;
            res1_tag   <= '0;
            for (int unsigned i = 0; i < LAT; i++)
                trk_tag[i] <= '0;
        end else begin
            trk_v      <= {trk_v[LAT-2:0], grant};
            trk_id     <= {trk_id[LAT-2:0], win_id};
            trk_tag[0] <= win_tag;
            for (int unsigned i = 1; i < LAT; i++)
                trk_tag[i] <= trk_tag[i-1];

            res0_valid <= retire && !trk_id[LAT-1];
            res1_valid <= retire && trk_id[LAT-1];
            res0_tag   <= (retire && !trk_id[LAT-1]) ? trk_tag[LAT-1] : '0;
            res1_tag   <= (retire && trk_id[LAT-1]) ? trk_tag[LAT-1] : '0;

            if (grant) begin
                mul_a <= win_a;
                mul_b <= win_b;
            end

            case ({grant, retire})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase

            case (state)
                RUN: begin
                    if (win_valid && (win_mod != cur_mod)) begin
                        pend_mod <= win_mod;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt == '0)
                        state <= SWITCH;
                end
                SWITCH: begin
                    cur_mod <= pend_mod;
                    state   <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_coeff_mult_arbiter.sv
// Bench for coeff_mult_arbiter: directed and random traffic scored against a behavioural model,
// with a LAT-cycle modular multiplier model driving mul_c.
module tb_coeff_mult_arbiter;
    localparam int LAT   = 9;
    localparam int TAG_W = 8;
    localparam longint unsigned Q0 = 64'd998244353;
    localparam longint unsigned Q1 = 64'd754974721;
`ifdef COEFF_MULT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic             rq0_ready, rq1_ready;
    logic [29:0]      rq0_a = '0, rq0_b = '0, rq1_a = '0, rq1_b = '0;
    logic             rq0_mod = 1'b0, rq1_mod = 1'b0;
    logic [TAG_W-1:0] rq0_tag = '0, rq1_tag = '0;
    logic [29:0]      mul_a, mul_b, mul_c;
    logic             mul_modulus_sel;
    logic             res0_valid, res1_valid;
    logic [29:0]      res0_data, res1_data;
    logic [TAG_W-1:0] res0_tag, res1_tag;
    logic             busy;

    always #5 clk = ~clk;

    coeff_mult_arbiter #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_a(rq0_a), .rq0_b(rq0_b),
        .rq0_mod(rq0_mod), .rq0_tag(rq0_tag),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_a(rq1_a), .rq1_b(rq1_b),
        .rq1_mod(rq1_mod), .rq1_tag(rq1_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_modulus_sel(mul_modulus_sel), .mul_c(mul_c),
        .res0_valid(res0_valid), .res0_data(res0_data), .res0_tag(res0_tag),
        .res1_valid(res1_valid), .res1_data(res1_data), .res1_tag(res1_tag),
        .busy(busy)
    );

    function automatic logic [29:0] modmul(input logic [29:0] a, input logic [29:0] b, input logic m);
        longint unsigned pa, pb;
        pa = 64'(a);
        pb = 64'(b);
        return 30'((pa * pb) % (m ? Q1 : Q0));
    endfunction

    // Shared multiplier: product of the operands presented in cycle k appears on mul_c in cycle k+LAT.
    logic [29:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= modmul(mul_a, mul_b, mul_modulus_sel);
        for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
    end
    assign mul_c = pipe[LAT-1];

    typedef struct packed {
        logic             id;
        logic [29:0]      data;
        logic [TAG_W-1:0] tag;
        int               due;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Pending request per port (held until accepted) and the reference arbitration model.
    logic             p_v [2];
    logic [29:0]      p_a [2];
    logic [29:0]      p_b [2];
    logic             p_m [2];
    logic [TAG_W-1:0] p_t [2];
    logic             m_mod;
    logic             m_ptr;
    int               m_run_from;
    int               m_last_acc;
    int               n_grant [2];

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic new_op(input int p, input logic [29:0] a, input logic [29:0] b,
                          input logic m, input logic [TAG_W-1:0] t);
        p_v[p] = 1'b1;
        p_a[p] = a;
        p_b[p] = b;
        p_m[p] = m;
        p_t[p] = t;
    endtask

    // One clock cycle: entered just after a falling edge, leaves at the next falling edge.
    task automatic step();
        int   w;
        int   g;
        exp_t e;
        rq0_valid = p_v[0]; rq0_a = p_a[0]; rq0_b = p_b[0]; rq0_mod = p_m[0]; rq0_tag = p_t[0];
        rq1_valid = p_v[1]; rq1_a = p_a[1]; rq1_b = p_b[1]; rq1_mod = p_m[1]; rq1_tag = p_t[1];
        #1;
        g = -1;
        if (cyc >= m_run_from) begin
            check("mul_modulus_sel", longint'(mul_modulus_sel), longint'(m_mod));
            if (p_v[0] || p_v[1]) begin
                if (p_v[0] && p_v[1])
                    w = RR ? int'(m_ptr) : 0;
                else
                    w = p_v[0] ? 0 : 1;
                if (p_m[w] == m_mod) begin
                    g = w;
                end else begin
                    // Wait for every accepted op to retire, then one switch cycle.
                    m_run_from = max2(cyc + 1, m_last_acc + LAT + 1) + 2;
                    m_mod      = p_m[w];
                end
            end
        end
        check("rq0_ready", longint'(rq0_ready), longint'(g == 0));
        check("rq1_ready", longint'(rq1_ready), longint'(g == 1));
        if (g >= 0) begin
            e.id   = g[0];
            e.data = modmul(p_a[g], p_b[g], p_m[g]);
            e.tag  = p_t[g];
            e.due  = cyc + LAT + 1;
            expq.push_back(e);
            m_last_acc = cyc;
            m_ptr      = (g == 0);
            n_grant[g]++;
            p_v[g]     = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        rq0_valid = 1'b1;
        rq1_valid = 1'b1;
        expq.delete();
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        m_mod = 1'b0; m_ptr = 1'b0; m_run_from = 0; m_last_acc = -1000;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Monitor: pops the scoreboard whenever a result is due and checks what the DUT presents.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            check("reset_rq0_ready", longint'(rq0_ready), 0);
            check("reset_rq1_ready", longint'(rq1_ready), 0);
            check("reset_res_valid", longint'({res0_valid, res1_valid}), 0);
            check("reset_res_data", longint'({res0_data, res1_data}), 0);
            check("reset_res_tag", longint'({res0_tag, res1_tag}), 0);
            check("reset_mul_ab", longint'({mul_a, mul_b}), 0);
            check("reset_mul_modulus_sel", longint'(mul_modulus_sel), 0);
            check("reset_busy", longint'(busy), 0);
        end else begin
            check("res_onehot", longint'(res0_valid & res1_valid), 0);
            if (expq.size() > 0 && expq[0].due == cyc) begin
                mon_e = expq.pop_front();
                check("res_valid", longint'(res0_valid | res1_valid), 1);
                check("res_id", longint'(res1_valid), longint'(mon_e.id));
                check("res_data", longint'(mon_e.id ? res1_data : res0_data), longint'(mon_e.data));
                check("res_tag", longint'(mon_e.id ? res1_tag : res0_tag), longint'(mon_e.tag));
            end else begin
                check("res_spurious", longint'(res0_valid | res1_valid), 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          base;
        logic        rmod;
        logic [TAG_W-1:0] tag_ctr;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0;
        p_m[0] = 1'b0; p_m[1] = 1'b0; p_t[0] = '0; p_t[1] = '0;
        n_grant[0] = 0; n_grant[1] = 0;
        @(negedge clk);
        do_reset(3);

        // Single operation, granted on the first edge after reset release.
        new_op(0, 30'd3, 30'd5, 1'b0, 8'h11);
        step();
        idle(LAT + 3);
        check("single_busy_after", longint'(busy), 0);

        // Streaming: one op per cycle, tags 0..19; busy held while occupancy is full.
        base = n_grant[0];
        for (int i = 0; i < 20; i++) begin
            new_op(0, 30'($urandom), 30'($urandom), 1'b0, TAG_W'(i));
            step();
            if (i == 15)
                check("stream_busy_full", longint'(busy), 1);
        end
        check("stream_grants", longint'(n_grant[0] - base), 20);
        idle(LAT + 3);

        // Modulus switch: four mod-0 ops then one mod-1 op.
        base = n_grant[0];
        k = 0;
        for (int c = 0; c < 60 && (n_grant[0] - base) < 5; c++) begin
            if (!p_v[0] && k < 5) begin
                new_op(0, 30'($urandom), 30'($urandom), (k == 4), TAG_W'(8'h40 + k));
                k++;
            end
            step();
        end
        check("modsw_grants", longint'(n_grant[0] - base), 5);
        idle(LAT + 3);

        // Reset mid-flight: three accepted ops are discarded.
        for (int i = 0; i < 3; i++) begin
            new_op(0, 30'($urandom), 30'($urandom), 1'b1, TAG_W'(8'h80 + i));
            step();
        end
        do_reset(2);
        idle(2 * LAT);

        // Contention: both requesters valid every cycle with the same modulus.
        base = n_grant[0];
        k = n_grant[1];
        for (int i = 0; i < 12; i++) begin
            if (!p_v[0]) new_op(0, 30'($urandom), 30'($urandom), 1'b0, TAG_W'(8'hA0 + i));
            if (!p_v[1]) new_op(1, 30'($urandom), 30'($urandom), 1'b0, TAG_W'(8'hC0 + i));
            step();
        end
        check("contend_grants0", longint'(n_grant[0] - base), RR ? 6 : 12);
        check("contend_grants1", longint'(n_grant[1] - k), RR ? 6 : 0);
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        idle(LAT + 3);

        // Random traffic with occasional modulus changes.
        rmod = 1'b0;
        tag_ctr = '0;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 15) == 0) rmod = ~rmod;
            for (int p = 0; p < 2; p++) begin
                if (!p_v[p] && $urandom_range(0, 1) == 1) begin
                    new_op(p, 30'($urandom), 30'($urandom),
                           ($urandom_range(0, 7) == 0) ? ~rmod : rmod, tag_ctr);
                    tag_ctr++;
                end
            end
            step();
        end
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        idle(2 * LAT + 6);
        check("scoreboard_empty", longint'(expq.size()), 0);
        check("final_busy", longint'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
